// File: rtl/core_pkg.sv
// Shared core constants: default widths and ABI register indices.
package core_pkg;

  localparam int unsigned XLEN_DEF = 32;
  localparam int unsigned NREG_DEF = 32;
  localparam int unsigned AW_DEF   = 5;

  localparam int unsigned REG_ZERO = 0;

  // ABI register names
  localparam int unsigned RA = 1;
  localparam int unsigned SP = 2;
  localparam int unsigned GP = 3;
  localparam int unsigned TP = 4;
  localparam int unsigned T0 = 5;
  localparam int unsigned T1 = 6;
  localparam int unsigned T2 = 7;
  localparam int unsigned S0 = 8;
  localparam int unsigned S1 = 9;
  localparam int unsigned A0 = 10;
  localparam int unsigned A1 = 11;

endpackage

// File: rtl/reg_file_sb_if.sv
// Decode / write-back / issue bus between the pipeline and the register file.
interface reg_file_sb_if import core_pkg::*; #(
  parameter int unsigned XLEN = XLEN_DEF,
  parameter int unsigned NREG = NREG_DEF,
  parameter int unsigned AW   = AW_DEF
);

  logic [AW-1:0]   rs1_addr;
  logic [AW-1:0]   rs2_addr;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            rs1_busy;
  logic            rs2_busy;
  logic            wb_en;
  logic [AW-1:0]   wb_addr;
  logic [XLEN-1:0] wb_data;
  logic            issue_en;
  logic [AW-1:0]   issue_rd;
  logic            flush;
  logic [NREG-1:0] busy_vec;

  modport master (
    output rs1_addr, rs2_addr, wb_en, wb_addr, wb_data, issue_en, issue_rd, flush,
    input  rs1_data, rs2_data, rs1_busy, rs2_busy, busy_vec
  );

  modport slave (
    input  rs1_addr, rs2_addr, wb_en, wb_addr, wb_data, issue_en, issue_rd, flush,
    output rs1_data, rs2_data, rs1_busy, rs2_busy, busy_vec
  );

endinterface

// File: rtl/reg_file_sb_scoreboard.sv
// Per-register busy bits: flush > issue set > write-back clear.
module reg_scoreboard import core_pkg::*; #(
  parameter int unsigned NREG   = NREG_DEF,
  parameter int unsigned AW     = AW_DEF,
  parameter bit          BYPASS = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            issue_en,
  input  logic [AW-1:0]   issue_rd,
  input  logic            wb_en,
  input  logic [AW-1:0]   wb_addr,
  input  logic            flush,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [NREG-1:0] busy_vec,
  output logic            rs1_busy,
  output logic            rs2_busy
);

  logic [NREG-1:0] busy;
  logic            clr1;
  logic            clr2;

  // Busy state update; bit 0 is only ever reset, so it stays 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else begin
      for (int unsigned r = 1; r < NREG; r++) begin
        if (flush)                             busy[r] <= 1'b0;
        else if (issue_en && issue_rd == AW'(r)) busy[r] <= 1'b1;
        else if (wb_en && wb_addr == AW'(r))     busy[r] <= 1'b0;
      end
    end
  end

  // A forwarded write-back clears the looked-up bit unless a newer writer issues now.
  always_comb begin
    clr1 = BYPASS && wb_en && (wb_addr == rs1_addr) && !(issue_en && issue_rd == rs1_addr);
    clr2 = BYPASS && wb_en && (wb_addr == rs2_addr) && !(issue_en && issue_rd == rs2_addr);
  end

  assign rs1_busy = busy[rs1_addr] & ~clr1;
  assign rs2_busy = busy[rs2_addr] & ~clr2;
  assign busy_vec = busy;

endmodule

// File: rtl/reg_file_sb.sv
// Integer register file with write-to-read bypass and busy scoreboard.
module reg_file_sb import core_pkg::*; #(
  parameter int unsigned XLEN   = XLEN_DEF,
  parameter int unsigned NREG   = NREG_DEF,
  parameter int unsigned AW     = AW_DEF,
  parameter bit          BYPASS = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  reg_file_sb_if.slave bus
);

  logic [XLEN-1:0] mem [NREG];
  logic [XLEN-1:0] rd1;
  logic [XLEN-1:0] rd2;

  // Storage write; x0 is never written so it stays at its reset value of 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREG; i++) mem[i] <= '0;
    end else if (bus.wb_en && bus.wb_addr != AW'(REG_ZERO)) begin
      mem[bus.wb_addr] <= bus.wb_data;
    end
  end

  // Zero-latency read muxes with optional same-cycle forwarding.
  always_comb begin
    rd1 = mem[bus.rs1_addr];
    rd2 = mem[bus.rs2_addr];
    if (bus.rs1_addr == AW'(REG_ZERO))
      rd1 = '0;
    else if (BYPASS && bus.wb_en && bus.wb_addr == bus.rs1_addr)
      rd1 = bus.wb_data;
    if (bus.rs2_addr == AW'(REG_ZERO))
      rd2 = '0;
    else if (BYPASS && bus.wb_en && bus.wb_addr == bus.rs2_addr)
      rd2 = bus.wb_data;
  end

  assign bus.rs1_data = rd1;
  assign bus.rs2_data = rd2;

  reg_scoreboard #(.NREG(NREG), .AW(AW), .BYPASS(BYPASS)) u_sb (
    .clk      (clk),
    .rst      (rst),
    .issue_en (bus.issue_en),
    .issue_rd (bus.issue_rd),
    .wb_en    (bus.wb_en),
    .wb_addr  (bus.wb_addr),
    .flush    (bus.flush),
    .rs1_addr (bus.rs1_addr),
    .rs2_addr (bus.rs2_addr),
    .busy_vec (bus.busy_vec),
    .rs1_busy (bus.rs1_busy),
    .rs2_busy (bus.rs2_busy)
  );

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: one BYPASS=1 and one BYPASS=0 instance on shared stimulus.
module tb_reg_file_sb;
  import core_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs1_addr, rs2_addr, wb_addr, issue_rd;
  logic [31:0] wb_data;
  logic        wb_en, issue_en, flush;

  int checks = 0;
  int errors = 0;

  reg_file_sb_if #(.XLEN(32), .NREG(32), .AW(5)) if1 ();
  reg_file_sb_if #(.XLEN(32), .NREG(32), .AW(5)) if0 ();

  assign if1.rs1_addr = rs1_addr;  assign if0.rs1_addr = rs1_addr;
  assign if1.rs2_addr = rs2_addr;  assign if0.rs2_addr = rs2_addr;
  assign if1.wb_en    = wb_en;     assign if0.wb_en    = wb_en;
  assign if1.wb_addr  = wb_addr;   assign if0.wb_addr  = wb_addr;
  assign if1.wb_data  = wb_data;   assign if0.wb_data  = wb_data;
  assign if1.issue_en = issue_en;  assign if0.issue_en = issue_en;
  assign if1.issue_rd = issue_rd;  assign if0.issue_rd = issue_rd;
  assign if1.flush    = flush;     assign if0.flush    = flush;

  reg_file_sb #(.XLEN(32), .NREG(32), .AW(5), .BYPASS(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(if1));
  reg_file_sb #(.XLEN(32), .NREG(32), .AW(5), .BYPASS(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(if0));

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d1b, d2b, d1n, d2n;
    logic        b1b, b2b, b1n, b2n;
    logic [31:0] vec;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] m_mem [32];
  logic [31:0] m_busy;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wb_en = 1'b0; issue_en = 1'b0; flush = 1'b0;
    wb_addr = '0; issue_rd = '0; wb_data = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle(); rs1_addr = 5'(T0); rs2_addr = 5'(T0);
    tick(); tick();
    checks++;
    if (if1.busy_vec !== 32'h0 || if1.rs1_data !== 32'h0) begin
      errors++; $display("FAIL reset_hold data=%h vec=%h want 0/0", if1.rs1_data, if1.busy_vec);
    end
    rst = 1'b0;
    tick();
    wb_en = 1'b1; wb_addr = 5'(T0); wb_data = 32'hDEADBEEF; issue_en = 1'b1; issue_rd = 5'(T0);
    tick();
    idle();
    #1;
    checks++;
    if (if0.rs1_data !== 32'hDEADBEEF || if0.rs1_busy !== 1'b1) begin
      errors++; $display("FAIL reset_pre data=%h busy=%b want deadbeef/1", if0.rs1_data, if0.rs1_busy);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (if1.rs1_data !== 32'h0 || if1.rs1_busy !== 1'b0 || if1.busy_vec !== 32'h0 ||
        if0.rs1_data !== 32'h0 || if0.rs1_busy !== 1'b0 || if0.busy_vec !== 32'h0) begin
      errors++; $display("FAIL reset_async data=%h/%h busy=%b/%b vec=%h/%h want 0",
        if1.rs1_data, if0.rs1_data, if1.rs1_busy, if0.rs1_busy, if1.busy_vec, if0.busy_vec);
    end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_x0_write();
    wb_en = 1'b1; wb_addr = 5'(REG_ZERO); wb_data = 32'h12345678;
    issue_en = 1'b1; issue_rd = 5'(REG_ZERO);
    rs1_addr = 5'(REG_ZERO); rs2_addr = 5'(REG_ZERO);
    #1;
    checks++;
    if (if1.rs1_data !== 32'h0 || if1.rs2_data !== 32'h0) begin
      errors++; $display("FAIL x0_fwd got %h %h want 0", if1.rs1_data, if1.rs2_data);
    end
    tick();
    idle();
    #1;
    checks++;
    if (if1.rs1_data !== 32'h0 || if1.rs2_data !== 32'h0 || if0.rs1_data !== 32'h0 ||
        if0.rs2_data !== 32'h0 || if1.busy_vec !== 32'h0) begin
      errors++; $display("FAIL x0_read got %h %h %h %h vec=%h want 0",
        if1.rs1_data, if1.rs2_data, if0.rs1_data, if0.rs2_data, if1.busy_vec);
    end
  endtask

  task automatic test_bypass();
    wb_en = 1'b1; wb_addr = 5'(T2); wb_data = 32'h00000011;
    tick();
    wb_data = 32'hA5A5A5A5; rs1_addr = 5'(T2); rs2_addr = 5'(T2);
    #1;
    checks++;
    if (if1.rs1_data !== 32'hA5A5A5A5 || if1.rs2_data !== 32'hA5A5A5A5) begin
      errors++; $display("FAIL bypass_on got %h %h want a5a5a5a5", if1.rs1_data, if1.rs2_data);
    end
    checks++;
    if (if0.rs1_data !== 32'h00000011 || if0.rs2_data !== 32'h00000011) begin
      errors++; $display("FAIL bypass_off_old got %h %h want 00000011", if0.rs1_data, if0.rs2_data);
    end
    tick();
    idle();
    #1;
    checks++;
    if (if0.rs1_data !== 32'hA5A5A5A5 || if0.rs2_data !== 32'hA5A5A5A5) begin
      errors++; $display("FAIL bypass_off_new got %h %h want a5a5a5a5", if0.rs1_data, if0.rs2_data);
    end
  endtask

  task automatic test_busy();
    issue_en = 1'b1; issue_rd = 5'(GP);
    tick();
    idle(); rs1_addr = 5'(GP); rs2_addr = 5'(RA);
    #1;
    checks++;
    if (if1.rs1_busy !== 1'b1 || if0.rs1_busy !== 1'b1 || if1.rs2_busy !== 1'b0 ||
        if1.busy_vec !== 32'h00000008) begin
      errors++; $display("FAIL busy_set got %b %b %b vec=%h want 1 1 0 00000008",
        if1.rs1_busy, if0.rs1_busy, if1.rs2_busy, if1.busy_vec);
    end
    wb_en = 1'b1; wb_addr = 5'(GP); wb_data = 32'h55;
    #1;
    checks++;
    if (if1.rs1_busy !== 1'b0 || if0.rs1_busy !== 1'b1) begin
      errors++; $display("FAIL busy_fwd got %b %b want 0 1", if1.rs1_busy, if0.rs1_busy);
    end
    tick();
    idle();
    #1;
    checks++;
    if (if1.rs1_busy !== 1'b0 || if0.rs1_busy !== 1'b0 || if0.rs1_data !== 32'h55 ||
        if1.busy_vec !== 32'h0) begin
      errors++; $display("FAIL busy_clr got %b %b data=%h vec=%h want 0 0 55 0",
        if1.rs1_busy, if0.rs1_busy, if0.rs1_data, if1.busy_vec);
    end
  endtask

  task automatic test_issue_vs_wb();
    issue_en = 1'b1; issue_rd = 5'(S1);
    tick();
    wb_en = 1'b1; wb_addr = 5'(S1); wb_data = 32'h99; rs1_addr = 5'(S1);
    #1;
    checks++;
    if (if1.rs1_busy !== 1'b1) begin
      errors++; $display("FAIL issue_beats_fwd got %b want 1", if1.rs1_busy);
    end
    tick();
    idle();
    #1;
    checks++;
    if (if0.rs1_busy !== 1'b1 || if0.rs1_data !== 32'h99 || if1.busy_vec !== 32'h00000200) begin
      errors++; $display("FAIL issue_beats_wb busy=%b data=%h vec=%h want 1 99 00000200",
        if0.rs1_busy, if0.rs1_data, if1.busy_vec);
    end
    flush = 1'b1; issue_en = 1'b1; issue_rd = 5'(S1); issue_en = 1'b1;
    wb_en = 1'b1; wb_addr = 5'(A0); wb_data = 32'h77;
    tick();
    idle(); rs2_addr = 5'(A0);
    #1;
    checks++;
    if (if1.busy_vec !== 32'h0 || if0.busy_vec !== 32'h0 || if0.rs2_data !== 32'h77) begin
      errors++; $display("FAIL flush vec=%h/%h data=%h want 0/0 77", if1.busy_vec, if0.busy_vec, if0.rs2_data);
    end
  endtask

  task automatic test_random();
    exp_t e, g;
    int   bad = 0;
    rst = 1'b1; idle();
    #1;
    rst = 1'b0;
    for (int i = 0; i < 32; i++) m_mem[i] = '0;
    m_busy = '0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      issue_en = ($urandom_range(1) == 1);
      issue_rd = 5'($urandom_range(31));
      wb_en    = ($urandom_range(1) == 1);
      wb_addr  = ($urandom_range(3) == 0) ? issue_rd : 5'($urandom_range(31));
      wb_data  = $urandom;
      flush    = ($urandom_range(19) == 0);
      rs1_addr = ($urandom_range(3) == 0) ? wb_addr : 5'($urandom_range(31));
      rs2_addr = ($urandom_range(3) == 0) ? rs1_addr : 5'($urandom_range(31));
      // expected combinational outputs from the model state
      e.d1n = (rs1_addr == 0) ? 32'h0 : m_mem[rs1_addr];
      e.d2n = (rs2_addr == 0) ? 32'h0 : m_mem[rs2_addr];
      e.d1b = (rs1_addr != 0 && wb_en && wb_addr == rs1_addr) ? wb_data : e.d1n;
      e.d2b = (rs2_addr != 0 && wb_en && wb_addr == rs2_addr) ? wb_data : e.d2n;
      e.b1n = m_busy[rs1_addr];
      e.b2n = m_busy[rs2_addr];
      e.b1b = (wb_en && wb_addr == rs1_addr && !(issue_en && issue_rd == rs1_addr)) ? 1'b0 : e.b1n;
      e.b2b = (wb_en && wb_addr == rs2_addr && !(issue_en && issue_rd == rs2_addr)) ? 1'b0 : e.b2n;
      e.vec = m_busy;
      sb_q.push_back(e);
      #1;
      g = sb_q.pop_front();
      checks++;
      if (if1.rs1_data !== g.d1b || if1.rs2_data !== g.d2b || if0.rs1_data !== g.d1n ||
          if0.rs2_data !== g.d2n || if1.rs1_busy !== g.b1b || if1.rs2_busy !== g.b2b ||
          if0.rs1_busy !== g.b1n || if0.rs2_busy !== g.b2n || if1.busy_vec !== g.vec ||
          if0.busy_vec !== g.vec) begin
        errors++;
        if (bad < 10)
          $display("FAIL random cyc=%0d got %h %h %h %h %b%b%b%b %h want %h %h %h %h %b%b%b%b %h", cyc,
            if1.rs1_data, if1.rs2_data, if0.rs1_data, if0.rs2_data,
            if1.rs1_busy, if1.rs2_busy, if0.rs1_busy, if0.rs2_busy, if1.busy_vec,
            g.d1b, g.d2b, g.d1n, g.d2n, g.b1b, g.b2b, g.b1n, g.b2n, g.vec);
        bad++;
      end
      tick();
      if (wb_en && wb_addr != 0) m_mem[wb_addr] = wb_data;
      for (int r = 1; r < 32; r++) begin
        if (flush)                                m_busy[r] = 1'b0;
        else if (issue_en && issue_rd == 5'(r))   m_busy[r] = 1'b1;
        else if (wb_en && wb_addr == 5'(r))       m_busy[r] = 1'b0;
      end
    end
    idle();
  endtask

  initial begin
    rst = 1'b1; idle(); rs1_addr = '0; rs2_addr = '0;
    test_reset();
    test_x0_write();
    test_bypass();
    test_busy();
    test_issue_vs_wb();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised integer register file for the pipelined core; replaces the single-cycle register file.
- Register count, data width and write-to-read bypass are set by parameters.
- Adds a per-register busy scoreboard: decode/issue marks a destination pending, write-back clears it.
- Decode stage reads operands and busy flags; write-back stage drives the write port.

Parameters:
XLEN, 32, data width of each register
NREG, 32, number of architectural registers (power of two, >=2); register 0 is hard-wired zero
AW, 5, register address width, must equal log2(NREG)
BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = reads return stored value only

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
rs1_addr  input  AW  read port 1 address
rs2_addr  input  AW  read port 2 address
rs1_data  output  XLEN  read port 1 data (combinational)
rs2_data  output  XLEN  read port 2 data (combinational)
rs1_busy  output  1  read port 1 register has a pending write
rs2_busy  output  1  read port 2 register has a pending write
wb_en  input  1  write-back enable
wb_addr  input  AW  write-back destination
wb_data  input  XLEN  write-back data
issue_en  input  1  instruction with destination issued this cycle
issue_rd  input  AW  destination of issued instruction
flush  input  1  pipeline flush: clear all busy bits
busy_vec  output  NREG  full scoreboard, for debug and stall logic

Behaviour:
- Reset: clk and rst are the only clock and reset; rst is asynchronous, active-high.
  - While rst is high, all registers are 0 and all busy bits are 0.
  - Outputs then read 0 data and 0 busy for any address.
  - Reset mid-operation discards pending writes and scoreboard state at once.
- Write: on rising clk, if wb_en and wb_addr != 0, then reg[wb_addr] <= wb_data. Writes to address 0 are ignored.
- Read is combinational and has zero latency:
  - Address 0 returns 0.
  - Otherwise, if BYPASS=1, wb_en and wb_addr == rsX_addr, return wb_data.
  - Otherwise return reg[rsX_addr].
  - With BYPASS=0, a write becomes visible the cycle after its clock edge.
- Scoreboard: one bit per register; bit 0 is constant 0. On rising clk, for each register r != 0:
  - If flush: busy[r] <= 0. Flush has priority over all other events; a write in the same cycle still updates the register.
  - Else if issue_en and issue_rd == r: busy[r] <= 1. Issue beats a same-cycle write-back to the same r, because the newer writer is now pending.
  - Else if wb_en and wb_addr == r: busy[r] <= 0.
  - Otherwise hold.
- issue_en with issue_rd == 0 has no effect.
- A write-back to a register that is not busy is legal; it writes, and busy stays 0.
- rsX_busy = busy[rsX_addr] from the registered state. When BYPASS=1, a same-cycle write-back to that address forces rsX_busy to 0, unless a same-cycle issue also targets it.
- Both read ports may address the same register and get identical results.
- No internal counters; the scoreboard is a single bit per register. Multiple outstanding writers to one register are not tracked; stall logic must prevent them.

Decomposition:
- Shared package core_pkg holds:
  - XLEN_DEF = 32, NREG_DEF = 32, AW_DEF = 5
  - reg-index constant REG_ZERO = 0
  - ABI register-name constants (RA = 1, SP = 2, A0 = 10, ...) used by the bench and decoder
- One natural sub-module: reg_scoreboard (busy bits, set/clear/flush priority, busy lookups).
- The storage array and bypass muxes stay in reg_file_sb.

Test Plan:
1. Assert rst mid-run after writing x5 = 0xDEADBEEF -> rs1_data = 0 and rs1_busy = 0 immediately, before any clock edge; busy_vec = 0.
2. wb_en = 1, wb_addr = 0, wb_data = 0x12345678; then read x0 on both ports -> 0 on both.
3. BYPASS=1: wb_en, wb_addr = 7, wb_data = 0xA5A5A5A5 with rs1_addr = rs2_addr = 7 in the same cycle -> both data = 0xA5A5A5A5 that cycle. Repeat with BYPASS=0 -> old value that cycle, 0xA5A5A5A5 the next.
4. issue_en, issue_rd = 3 -> next cycle rs1_busy = 1 for x3. Then wb_en, wb_addr = 3, data 0x55 -> next cycle busy = 0 and data = 0x55.
5. Same cycle: issue_rd = 9 and wb_addr = 9 with x9 busy -> x9 stays busy and holds the written value. Flush plus issue_rd = 9 -> busy_vec = 0.
6. Random issue/write-back/flush sequence of 2000 cycles against a reference model -> data and busy match every cycle.
